mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
Main control state machine for the multi-cycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback steps. It drives every datapath enable and mux select, plus the 2-bit ALUOp consumed by the ALU control unit. It supports memory wait states through a ready handshake.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode (ALU function taken from funct via ALUOp=10)
OP_LW, 6'b100011, load word opcode
OP_SW, 6'b101011, store word opcode
OP_BEQ, 6'b000100, branch-equal opcode
OP_J, 6'b000010, jump opcode
OP_ADDI, 6'b001000, add-immediate opcode

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  6  opcode field of the instruction register (IR[31:26]); stable from DECODE onward
mem_ready  in  1  memory completes the current read/write this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load qualified by ALU zero (beq)
IorD  out  1  0 = memory address from PC, 1 = from ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  instruction register load
MemtoReg  out  1  1 = write-back from MDR, 0 = from ALUOut
RegDst  out  1  1 = rd, 0 = rt
RegWrite  out  1  register file write
ALUSrcA  out  1  0 = PC, 1 = register A
ALUSrcB  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
ALUOp  out  2  00 = add, 01 = subtract, 10 = decode funct
PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
instr_done  out  1  1-cycle pulse on the final cycle of each legal instruction
illegal_op  out  1  1-cycle pulse in DECODE for an unrecognised opcode
state  out  4  current state encoding (debug)

Behaviour:
- Outputs are a combinational decode of the state register. Exceptions are the mem_ready-qualified signals, which are also combinational. Any output not listed for a state is 0.
- rst_n low: state forced to FETCH immediately (asynchronous). All enables (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, instr_done, illegal_op) are forced 0 while rst_n=0. After release, the first cycle is FETCH. Reset mid-instruction abandons it without any write.
- States and transitions:
  - 0 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready. Go to DECODE when mem_ready, else stay.
  - 1 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precompute branch target). Next state by op:
    - LW or SW -> MEMADR
    - RTYPE -> EXEC
    - BEQ -> BRANCH
    - J -> JUMP
    - ADDI -> ADDIEX
    - other -> FETCH with illegal_op=1
  - 2 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD if op=LW, else MEMWR.
  - 3 MEMRD: MemRead=1, IorD=1. Go to MEMWB on mem_ready, else stay.
  - 4 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Go to FETCH.
  - 5 MEMWR: MemWrite=1, IorD=1, instr_done=mem_ready. Go to FETCH on mem_ready, else stay.
  - 6 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to ALUWB.
  - 7 ALUWB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. Go to FETCH.
  - 8 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. Go to FETCH.
  - 9 JUMP: PCWrite=1, PCSource=10, instr_done=1. Go to FETCH.
  - 10 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to ADDIWB.
  - 11 ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1. Go to FETCH.
  - 12-15: all outputs 0. Go to FETCH next cycle (recovery).
- Latency with mem_ready tied 1:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
  - Each wait cycle in FETCH, MEMRD or MEMWR adds 1 cycle.
- MemRead/MemWrite stay asserted for the whole wait and are never both high in the same cycle.
- RegWrite and PCWrite/PCWriteCond never assert in the same cycle.
- op is sampled only in DECODE and MEMADR; changes at other times have no effect.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with op=6'b100011 and mem_ready=1 -> state=0, all enables 0. First cycle after release: MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- R-type, mem_ready=1, op=6'b000000 -> states 0,1,6,7. ALUOp=10 in state 6. RegWrite=1 and RegDst=1 in state 7. instr_done pulses once, 4 cycles after FETCH entry.
- lw with 2 wait cycles in MEMRD (mem_ready low for 2 cycles), op=6'b100011 -> states 0,1,2,3,3,3,4,0. IorD=1 in 3. MemtoReg=1 and RegWrite=1 in 4. Total 7 cycles.
- sw then beq back-to-back, mem_ready=1:
  - sw -> 0,1,2,5, MemWrite=1 for exactly 1 cycle.
  - beq -> 0,1,8, ALUOp=01, PCWriteCond=1, PCSource=01.
- FETCH stall, then j: mem_ready=0 for 3 cycles -> IRWrite/PCWrite stay 0 and MemRead stays 1 throughout. Then op=6'b000010 -> state 9, PCWrite=1, PCSource=10.
- Illegal op 6'b111111 -> illegal_op=1 in DECODE, next state FETCH, no RegWrite/MemWrite. Separately, assert rst_n=0 during MEMRD -> state=0 asynchronously and RegWrite never asserts.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Main control sequencer for the multi-cycle MIPS datapath.
// Latency: control outputs are a same-cycle decode of the state register, plus mem_ready where noted.
// Backpressure: mem_ready low holds FETCH/MEMRD/MEMWR with the memory request still asserted.
module mc_control_fsm #(
   parameter logic [5:0] OP_RTYPE = 6'b000000,
   parameter logic [5:0] OP_LW    = 6'b100011,
   parameter logic [5:0] OP_SW    = 6'b101011,
   parameter logic [5:0] OP_BEQ   = 6'b000100,
   parameter logic [5:0] OP_J     = 6'b000010,
   parameter logic [5:0] OP_ADDI  = 6'b001000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       instr_done,
   output logic       illegal_op,
   output logic [3:0] state
);

   // Encodings 12..15 are unused; they decode to all-zero outputs and fall back to FETCH.
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11
   } state_t;

   state_t     r_state;
   state_t     w_next;

   // Raw decode before the reset gate on the write/request enables.
   logic       w_pc_write;
   logic       w_pc_write_cond;
   logic       w_mem_read;
   logic       w_mem_write;
   logic       w_ir_write;
   logic       w_reg_write;
   logic       w_instr_done;
   logic       w_illegal_op;
   logic       w_op_known;

   // Opcode recognition, only meaningful while in DECODE.
   always_comb begin
      w_op_known = 1'b0;
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: w_op_known = 1'b1;
         default:                                       w_op_known = 1'b0;
      endcase
   end

   // Next-state selection; op is only looked at in DECODE and MEMADR.
   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_RTYPE:     w_next = S_EXEC;
               OP_BEQ:       w_next = S_BRANCH;
               OP_J:         w_next = S_JUMP;
               OP_ADDI:      w_next = S_ADDIEX;
               default:      w_next = S_FETCH;
            endcase
         end
         S_MEMADR: w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:  w_next = S_FETCH;
         S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   w_next = S_ALUWB;
         S_ALUWB:  w_next = S_FETCH;
         S_BRANCH: w_next = S_FETCH;
         S_JUMP:   w_next = S_FETCH;
         S_ADDIEX: w_next = S_ADDIWB;
         S_ADDIWB: w_next = S_FETCH;
         default:  w_next = S_FETCH;
      endcase
   end

   // State register; reset lands in FETCH immediately, abandoning any instruction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   // Per-state control decode; anything not named for a state stays 0.
   always_comb begin
      w_pc_write      = 1'b0;
      w_pc_write_cond = 1'b0;
      w_mem_read      = 1'b0;
      w_mem_write     = 1'b0;
      w_ir_write      = 1'b0;
      w_reg_write     = 1'b0;
      w_instr_done    = 1'b0;
      w_illegal_op    = 1'b0;
      IorD            = 1'b0;
      MemtoReg        = 1'b0;
      RegDst          = 1'b0;
      ALUSrcA         = 1'b0;
      ALUSrcB         = 2'b00;
      ALUOp           = 2'b00;
      PCSource        = 2'b00;
      case (r_state)
         S_FETCH: begin
            // PC+4 is computed every fetch cycle but only committed with the instruction.
            w_mem_read = 1'b1;
            ALUSrcB    = 2'b01;
            w_ir_write = mem_ready;
            w_pc_write = mem_ready;
         end
         S_DECODE: begin
            // Branch target is precomputed here so BRANCH only needs the compare.
            ALUSrcB      = 2'b11;
            w_illegal_op = ~w_op_known;
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMRD: begin
            w_mem_read = 1'b1;
            IorD       = 1'b1;
         end
         S_MEMWB: begin
            w_reg_write  = 1'b1;
            MemtoReg     = 1'b1;
            w_instr_done = 1'b1;
         end
         S_MEMWR: begin
            w_mem_write  = 1'b1;
            IorD         = 1'b1;
            w_instr_done = mem_ready;
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
         end
         S_ALUWB: begin
            w_reg_write  = 1'b1;
            RegDst       = 1'b1;
            w_instr_done = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA         = 1'b1;
            ALUOp           = 2'b01;
            w_pc_write_cond = 1'b1;
            PCSource        = 2'b01;
            w_instr_done    = 1'b1;
         end
         S_JUMP: begin
            w_pc_write   = 1'b1;
            PCSource     = 2'b10;
            w_instr_done = 1'b1;
         end
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_ADDIWB: begin
            w_reg_write  = 1'b1;
            w_instr_done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Enables and pulses are held off for the whole reset window, not just after the edge.
   always_comb begin
      PCWrite     = w_pc_write      & rst_n;
      PCWriteCond = w_pc_write_cond & rst_n;
      MemRead     = w_mem_read      & rst_n;
      MemWrite    = w_mem_write     & rst_n;
      IRWrite     = w_ir_write      & rst_n;
      RegWrite    = w_reg_write     & rst_n;
      instr_done  = w_instr_done    & rst_n;
      illegal_op  = w_illegal_op    & rst_n;
      state       = r_state;
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] op;
   logic       mem_ready;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, illegal_op;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic [3:0] state;

   mc_control_fsm dut (
      .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op),
      .state(state)
   );

   always #5 clk = ~clk;

   // Control word layout used for every comparison.
   logic [17:0] w_ctrl;
   assign w_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                    MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                    PCSource, instr_done, illegal_op};

   localparam logic [17:0] PCW    = 18'h20000;
   localparam logic [17:0] PCWC   = 18'h10000;
   localparam logic [17:0] IORD   = 18'h08000;
   localparam logic [17:0] MRD    = 18'h04000;
   localparam logic [17:0] MWR    = 18'h02000;
   localparam logic [17:0] IRW    = 18'h01000;
   localparam logic [17:0] M2R    = 18'h00800;
   localparam logic [17:0] RDST   = 18'h00400;
   localparam logic [17:0] RW     = 18'h00200;
   localparam logic [17:0] SRCA   = 18'h00100;
   localparam logic [17:0] SB_4   = 18'h00040;
   localparam logic [17:0] SB_IMM = 18'h00080;
   localparam logic [17:0] SB_SH  = 18'h000C0;
   localparam logic [17:0] AO_SUB = 18'h00010;
   localparam logic [17:0] AO_FN  = 18'h00020;
   localparam logic [17:0] PS_OUT = 18'h00004;
   localparam logic [17:0] PS_J   = 18'h00008;
   localparam logic [17:0] DONE   = 18'h00002;
   localparam logic [17:0] ILL    = 18'h00001;
   localparam logic [17:0] ENABLES = PCW | PCWC | MRD | MWR | IRW | RW | DONE | ILL;

   localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
   localparam logic [5:0] BQ = 6'b000100, JP = 6'b000010, AI = 6'b001000;

   // Expected control words of the named steps.
   localparam logic [17:0] F1 = MRD | SB_4 | IRW | PCW;
   localparam logic [17:0] F0 = MRD | SB_4;
   localparam logic [17:0] DC = SB_SH;
   localparam logic [17:0] MA = SRCA | SB_IMM;

   int n_pass = 0;
   int n_total = 0;
   logic last_done;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   // Drive one cycle of inputs, compare mid-cycle, then advance past the next edge.
   task automatic step(input logic [5:0] o, input logic r, input logic [3:0] es,
                       input logic [17:0] ec, input string nm);
      op = o;
      mem_ready = r;
      #3;
      chk({nm, " state"}, {28'd0, state}, {28'd0, es});
      chk({nm, " ctrl"}, {14'd0, w_ctrl}, {14'd0, ec});
      chk({nm, " rd/wr exclusive"}, {31'd0, MemRead & MemWrite}, 32'd0);
      chk({nm, " regwr vs pcwr"}, {31'd0, RegWrite & (PCWrite | PCWriteCond)}, 32'd0);
      last_done = instr_done;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [5:0]  op;
      logic        rdy;
      logic [3:0]  st;
      logic [17:0] ctrl;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input logic [5:0] o, input logic r,
                              input logic [3:0] s, input logic [17:0] c);
      vec_t x;
      x.op = o; x.rdy = r; x.st = s; x.ctrl = c;
      return x;
   endfunction

   // Reference model: instruction-level step plans derived from the opcode and wait counts.
   function automatic logic legal(input logic [5:0] o);
      return (o == RT) || (o == LW) || (o == SW) || (o == BQ) || (o == JP) || (o == AI);
   endfunction

   function automatic logic [17:0] exp_ctrl(input logic [3:0] s, input logic r, input logic [5:0] o);
      case (s)
         4'd0:    return r ? F1 : F0;
         4'd1:    return legal(o) ? DC : (DC | ILL);
         4'd2:    return MA;
         4'd3:    return MRD | IORD;
         4'd4:    return RW | M2R | DONE;
         4'd5:    return MWR | IORD | (r ? DONE : 18'h0);
         4'd6:    return SRCA | AO_FN;
         4'd7:    return RW | RDST | DONE;
         4'd8:    return SRCA | AO_SUB | PCWC | PS_OUT | DONE;
         4'd9:    return PCW | PS_J | DONE;
         4'd10:   return MA;
         4'd11:   return RW | DONE;
         default: return 18'h0;
      endcase
   endfunction

   typedef struct {
      logic [3:0] st;
      logic       rdy;
   } plan_t;

   plan_t plan[$];

   function automatic plan_t p(input logic [3:0] s, input logic r);
      plan_t x;
      x.st = s; x.rdy = r;
      return x;
   endfunction

   initial begin
      int k, wf, wm, dones, lat;
      logic [5:0] opv, dop;

      // Reset held for 3 cycles with a load opcode and memory ready.
      rst_n = 1'b0; op = LW; mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("reset state", {28'd0, state}, 32'd0);
         chk("reset enables", {14'd0, w_ctrl & ENABLES}, 32'd0);
      end
      rst_n = 1'b1;

      // Directed cycle-by-cycle table, starting from the first cycle after release.
      tbl.push_back(v(RT, 1, 0, F1));
      tbl.push_back(v(RT, 1, 1, DC));
      tbl.push_back(v(RT, 1, 6, SRCA | AO_FN));
      tbl.push_back(v(RT, 1, 7, RW | RDST | DONE));
      tbl.push_back(v(LW, 1, 0, F1));
      tbl.push_back(v(LW, 1, 1, DC));
      tbl.push_back(v(LW, 1, 2, MA));
      tbl.push_back(v(LW, 0, 3, MRD | IORD));
      tbl.push_back(v(LW, 0, 3, MRD | IORD));
      tbl.push_back(v(LW, 1, 3, MRD | IORD));
      tbl.push_back(v(LW, 1, 4, RW | M2R | DONE));
      tbl.push_back(v(SW, 1, 0, F1));
      tbl.push_back(v(SW, 1, 1, DC));
      tbl.push_back(v(SW, 1, 2, MA));
      tbl.push_back(v(SW, 1, 5, MWR | IORD | DONE));
      tbl.push_back(v(BQ, 1, 0, F1));
      tbl.push_back(v(BQ, 1, 1, DC));
      tbl.push_back(v(BQ, 1, 8, SRCA | AO_SUB | PCWC | PS_OUT | DONE));
      tbl.push_back(v(JP, 0, 0, F0));
      tbl.push_back(v(JP, 0, 0, F0));
      tbl.push_back(v(JP, 0, 0, F0));
      tbl.push_back(v(JP, 1, 0, F1));
      tbl.push_back(v(JP, 1, 1, DC));
      tbl.push_back(v(JP, 1, 9, PCW | PS_J | DONE));
      tbl.push_back(v(6'h3F, 1, 0, F1));
      tbl.push_back(v(6'h3F, 1, 1, DC | ILL));
      tbl.push_back(v(AI, 1, 0, F1));
      tbl.push_back(v(AI, 1, 1, DC));
      tbl.push_back(v(AI, 1, 10, MA));
      tbl.push_back(v(AI, 1, 11, RW | DONE));
      foreach (tbl[i]) step(tbl[i].op, tbl[i].rdy, tbl[i].st, tbl[i].ctrl, $sformatf("vec%0d", i));

      // Reset asserted while a load waits in MEMRD: immediate return to FETCH, no write-back.
      step(LW, 1, 0, F1, "rstmid fetch");
      step(LW, 1, 1, DC, "rstmid decode");
      step(LW, 1, 2, MA, "rstmid memadr");
      step(LW, 0, 3, MRD | IORD, "rstmid memrd");
      #2;
      rst_n = 1'b0;
      #1;
      chk("async reset state", {28'd0, state}, 32'd0);
      chk("async reset enables", {14'd0, w_ctrl & ENABLES}, 32'd0);
      mem_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         chk("held reset state", {28'd0, state}, 32'd0);
         chk("held reset regwrite", {31'd0, RegWrite}, 32'd0);
      end
      rst_n = 1'b1;
      step(LW, 1, 0, F1, "post reset fetch");
      step(LW, 1, 1, DC, "post reset decode");
      step(LW, 1, 2, MA, "post reset memadr");
      step(LW, 1, 3, MRD | IORD, "post reset memrd");
      step(LW, 1, 4, RW | M2R | DONE, "post reset memwb");

      // Random instruction stream with random wait states; op is garbage outside DECODE/MEMADR.
      for (int n = 0; n < 250; n++) begin
         k = $urandom_range(0, 6);
         case (k)
            0: opv = RT;
            1: opv = LW;
            2: opv = SW;
            3: opv = BQ;
            4: opv = JP;
            5: opv = AI;
            default: begin
               opv = 6'($urandom);
               while (legal(opv)) opv = 6'($urandom);
            end
         endcase
         wf = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
         wm = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
         plan.delete();
         for (int i = 0; i < wf; i++) plan.push_back(p(0, 0));
         plan.push_back(p(0, 1));
         plan.push_back(p(1, $urandom_range(0, 1)));
         if (opv == LW) begin
            plan.push_back(p(2, $urandom_range(0, 1)));
            for (int i = 0; i < wm; i++) plan.push_back(p(3, 0));
            plan.push_back(p(3, 1));
            plan.push_back(p(4, $urandom_range(0, 1)));
         end else if (opv == SW) begin
            plan.push_back(p(2, $urandom_range(0, 1)));
            for (int i = 0; i < wm; i++) plan.push_back(p(5, 0));
            plan.push_back(p(5, 1));
         end else if (opv == RT) begin
            plan.push_back(p(6, $urandom_range(0, 1)));
            plan.push_back(p(7, $urandom_range(0, 1)));
         end else if (opv == BQ) begin
            plan.push_back(p(8, $urandom_range(0, 1)));
         end else if (opv == JP) begin
            plan.push_back(p(9, $urandom_range(0, 1)));
         end else if (opv == AI) begin
            plan.push_back(p(10, $urandom_range(0, 1)));
            plan.push_back(p(11, $urandom_range(0, 1)));
         end
         dones = 0;
         lat = 0;
         foreach (plan[i]) begin
            dop = (plan[i].st == 4'd1 || plan[i].st == 4'd2) ? opv : 6'($urandom);
            step(dop, plan[i].rdy, plan[i].st, exp_ctrl(plan[i].st, plan[i].rdy, dop), "rand");
            if (last_done) begin
               dones++;
               lat = i + 1;
            end
         end
         chk("rand done count", dones, legal(opv) ? 32'd1 : 32'd0);
         if (legal(opv)) begin
            k = (opv == LW) ? 5 : ((opv == BQ || opv == JP) ? 3 : 4);
            k = k + wf + ((opv == LW || opv == SW) ? wm : 0);
            chk("rand latency", lat, k);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
